// File: rtl/move_control_accel.sv
// move_control_accel: frame-rate cursor/sprite position controller.
// Buttons are synchronised, motion is applied once per frame on the rising
// edge of vs, and the step size ramps from SPEED_MIN up to SPEED_MAX while a
// direction is held. Each axis either clamps or wraps at its bounds.
//
// Handshake: there is no valid/ready pair. The frame tick (rising edge of vs)
// is the only qualifier. All registered outputs change only on the clock edge
// where tick is high and are valid from the following cycle. hit_edge is high
// for exactly that one following cycle.
module move_control_accel #(
    parameter int W            = 11,
    parameter int START_X      = 320,
    parameter int START_Y      = 240,
    parameter int MIN_X        = 30,
    parameter int MAX_X        = 610,
    parameter int MIN_Y        = 30,
    parameter int MAX_Y        = 450,
    parameter int SPD_W        = 4,
    parameter int SPEED_MIN    = 1,
    parameter int SPEED_MAX    = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int EDGE_MODE    = 0
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic             vs,
    input  logic             freeze,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [W-1:0]     cx,
    output logic [W-1:0]     cy,
    output logic [SPD_W-1:0] speed,
    output logic             moving,
    output logic             hit_edge
);

    // The frame counter only has to reach ACCEL_FRAMES-1.
    localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    localparam logic [SPD_W-1:0] SPD_MIN_V = SPD_W'(SPEED_MIN);
    localparam logic [SPD_W-1:0] SPD_MAX_V = SPD_W'(SPEED_MAX);

    // Bounds widened by one bit so target arithmetic never overflows.
    localparam logic [W:0] X_LO   = (W+1)'(MIN_X);
    localparam logic [W:0] X_HI   = (W+1)'(MAX_X);
    localparam logic [W:0] X_SPAN = (W+1)'(MAX_X - MIN_X + 1);
    localparam logic [W:0] Y_LO   = (W+1)'(MIN_Y);
    localparam logic [W:0] Y_HI   = (W+1)'(MAX_Y);
    localparam logic [W:0] Y_SPAN = (W+1)'(MAX_Y - MIN_Y + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        CRUISE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [SPD_W-1:0]   speed_nxt;
    logic [SPD_W-1:0]   speed_inc;
    logic [W-1:0]       cx_nxt;
    logic [W-1:0]       cy_nxt;
    logic               hit_nxt;

    // Button synchroniser stages, packed as {up, down, left, right}.
    logic [3:0]         btn_s1;
    logic [3:0]         btn_s2;
    logic               vs_d;
    logic               tick;

    logic               x_inc;
    logic               x_dec;
    logic               y_inc;
    logic               y_dec;
    logic               go;
    logic [SPD_W-1:0]   step;
    logic [W:0]         step_e;
    logic [W:0]         x_res;
    logic [W:0]         y_res;

    // One axis update. Returns {hit, new_pos}. The low-bound test is written
    // as pos < lo + s so the subtraction never has to go negative.
    function automatic logic [W:0] axis_next(
        input logic [W-1:0] pos,
        input logic         inc,
        input logic         dec,
        input logic [W:0]   s,
        input logic [W:0]   lo,
        input logic [W:0]   hi,
        input logic [W:0]   span
    );
        logic [W:0]   p;
        logic [W:0]   t;
        logic         hit;
        logic [W-1:0] np;
        p   = {1'b0, pos};
        t   = p + s;
        hit = 1'b0;
        np  = pos;
        if (inc) begin
            if (t > hi) begin
                hit = 1'b1;
                np  = (EDGE_MODE != 0) ? W'(t - span) : W'(hi);
            end else begin
                np  = W'(t);
            end
        end else if (dec) begin
            if (p < lo + s) begin
                hit = 1'b1;
                np  = (EDGE_MODE != 0) ? W'(p + span - s) : W'(lo);
            end else begin
                np  = W'(p - s);
            end
        end
        return {hit, np};
    endfunction

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 4'b0000;
            btn_s2 <= 4'b0000;
        end else begin
            btn_s1 <= {btn_up, btn_down, btn_left, btn_right};
            btn_s2 <= btn_s1;
        end
    end

    // Delayed vs for rising-edge detection; resets high so a vs already
    // high at reset release does not count as a new frame.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b1;
        end else begin
            vs_d <= vs;
        end
    end

    assign tick = vs & ~vs_d;

    // Opposing buttons on one axis cancel that axis only.
    assign x_inc = btn_s2[0] & ~btn_s2[1];
    assign x_dec = btn_s2[1] & ~btn_s2[0];
    assign y_inc = btn_s2[2] & ~btn_s2[3];
    assign y_dec = btn_s2[3] & ~btn_s2[2];
    assign go    = (x_inc | x_dec | y_inc | y_dec) & ~freeze;

    assign step   = (state == CRUISE) ? SPD_MAX_V : speed;
    assign step_e = (W+1)'(step);
    assign x_res  = axis_next(cx, x_inc, x_dec, step_e, X_LO, X_HI, X_SPAN);
    assign y_res  = axis_next(cy, y_inc, y_dec, step_e, Y_LO, Y_HI, Y_SPAN);

    assign moving = (state != IDLE);

    // Next-state, ramp and position decisions for the coming frame tick.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        speed_nxt = speed;
        speed_inc = speed + 1'b1;
        cx_nxt    = cx;
        cy_nxt    = cy;
        hit_nxt   = 1'b0;
        if (!go) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            speed_nxt = SPD_MIN_V;
        end else begin
            cx_nxt  = x_res[W-1:0];
            cy_nxt  = y_res[W-1:0];
            hit_nxt = x_res[W] | y_res[W];
            case (state)
                IDLE, RAMP: begin
                    if (speed >= SPD_MAX_V) begin
                        // Only reachable when SPEED_MIN == SPEED_MAX.
                        state_nxt = CRUISE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        speed_nxt = speed_inc;
                        state_nxt = (speed_inc == SPD_MAX_V) ? CRUISE : RAMP;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = RAMP;
                    end
                end
                CRUISE: begin
                    state_nxt = CRUISE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state register, advanced once per frame.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (tick) begin
            state <= state_nxt;
        end
    end

    // Position, speed and ramp counter; hit_edge only survives one cycle.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            cx       <= W'(START_X);
            cy       <= W'(START_Y);
            speed    <= SPD_MIN_V;
            cnt      <= '0;
            hit_edge <= 1'b0;
        end else if (tick) begin
            cx       <= cx_nxt;
            cy       <= cy_nxt;
            speed    <= speed_nxt;
            cnt      <= cnt_nxt;
            hit_edge <= hit_nxt;
        end else begin
            hit_edge <= 1'b0;
        end
    end

endmodule

// File: tb/tb_move_control_accel.sv
// Bench for move_control_accel: three instances (default, clamp near the
// right edge, wrap at the right edge) share all inputs. A frame-level model
// tracks each instance and is compared every cycle; directed literals pin it.
module tb_move_control_accel;

    logic pixel_clk = 1'b0;
    logic rst_n     = 1'b0;
    logic vs        = 1'b0;
    logic freeze    = 1'b0;
    logic btn_up    = 1'b0;
    logic btn_down  = 1'b0;
    logic btn_left  = 1'b0;
    logic btn_right = 1'b0;

    logic [10:0] cx_o  [3];
    logic [10:0] cy_o  [3];
    logic [3:0]  spd_o [3];
    logic        mov_o [3];
    logic        hit_o [3];

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 pixel_clk = ~pixel_clk;

    // ---------------- DUTs ----------------
    move_control_accel u_def (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vs(vs), .freeze(freeze),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .cx(cx_o[0]), .cy(cy_o[0]), .speed(spd_o[0]), .moving(mov_o[0]), .hit_edge(hit_o[0])
    );

    move_control_accel #(.START_X(608)) u_clamp (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vs(vs), .freeze(freeze),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .cx(cx_o[1]), .cy(cy_o[1]), .speed(spd_o[1]), .moving(mov_o[1]), .hit_edge(hit_o[1])
    );

    move_control_accel #(.START_X(610), .EDGE_MODE(1)) u_wrap (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .vs(vs), .freeze(freeze),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .cx(cx_o[2]), .cy(cy_o[2]), .speed(spd_o[2]), .moving(mov_o[2]), .hit_edge(hit_o[2])
    );

    // ---------------- checker ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int m_x [3];
    int m_y [3];
    int m_n [3];      // consecutive frames moved so far
    bit m_hit [3];
    bit m_s1 [4];     // button levels one and two clocks ago: up,down,left,right
    bit m_s2 [4];
    bit m_vsd;

    function automatic int start_x(input int i);
        return (i == 0) ? 320 : (i == 1) ? 608 : 610;
    endfunction

    // Step for a frame after n frames of continuous motion.
    function automatic int spd_of(input int n);
        int v;
        v = 1 + n / 4;
        return (v > 8) ? 8 : v;
    endfunction

    function automatic int move1(input int pos, input int d, input int s,
                                 input bit wrap, input int lo, input int hi,
                                 output bit hit);
        int t;
        int span;
        t    = pos + d * s;
        span = hi - lo + 1;
        hit  = 1'b0;
        if (t > hi) begin
            hit = 1'b1;
            return wrap ? t - span : hi;
        end
        if (t < lo) begin
            hit = 1'b1;
            return wrap ? t + span : lo;
        end
        return t;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_x[i] = start_x(i);
            m_y[i] = 240;
            m_n[i] = 0;
            m_hit[i] = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            m_s1[b] = 1'b0;
            m_s2[b] = 1'b0;
        end
        m_vsd = 1'b1;
    endtask

    initial begin
        int  dx;
        int  dy;
        int  s;
        bit  hx;
        bit  hy;
        bit  frame;
        bit  go;
        m_reset();
        forever begin
            @(posedge pixel_clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                frame = vs && !m_vsd;
                dx = (m_s2[3] && !m_s2[2]) ? 1 : (m_s2[2] && !m_s2[3]) ? -1 : 0;
                dy = (m_s2[1] && !m_s2[0]) ? 1 : (m_s2[0] && !m_s2[1]) ? -1 : 0;
                go = (dx != 0 || dy != 0) && !freeze;
                for (int i = 0; i < 3; i++) begin
                    m_hit[i] = 1'b0;
                    if (frame) begin
                        if (go) begin
                            s = spd_of(m_n[i]);
                            m_x[i] = move1(m_x[i], dx, s, i == 2, 30, 610, hx);
                            m_y[i] = move1(m_y[i], dy, s, i == 2, 30, 450, hy);
                            m_hit[i] = hx | hy;
                            m_n[i]++;
                        end else begin
                            m_n[i] = 0;
                        end
                    end
                end
                for (int b = 0; b < 4; b++) m_s2[b] = m_s1[b];
                m_s1[0] = btn_up;
                m_s1[1] = btn_down;
                m_s1[2] = btn_left;
                m_s1[3] = btn_right;
                m_vsd = vs;
            end
        end
    end

    // Compare every instance against the model on every falling edge.
    initial begin
        forever begin
            @(negedge pixel_clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cx%0d", i), cx_o[i], m_x[i]);
                chk($sformatf("cy%0d", i), cy_o[i], m_y[i]);
                chk($sformatf("speed%0d", i), spd_o[i], spd_of(m_n[i]));
                chk($sformatf("moving%0d", i), mov_o[i], (m_n[i] > 0) ? 1 : 0);
                chk($sformatf("hit_edge%0d", i), hit_o[i], m_hit[i]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
        @(posedge pixel_clk);
        #1;
        btn_up = u;
        btn_down = d;
        btn_left = l;
        btn_right = r;
        repeat (3) @(posedge pixel_clk);
        #1;
    endtask

    // One vs rising edge; returns 1ns after the edge where the tick is applied.
    task automatic do_tick();
        @(posedge pixel_clk);
        #1 vs = 1'b1;
        @(posedge pixel_clk);
        #1 vs = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int exp_cx  [9] = '{321, 322, 323, 324, 326, 328, 330, 332, 335};
    int exp_spd [9] = '{1, 1, 1, 2, 2, 2, 2, 3, 3};
    int exp_ccx [3] = '{609, 610, 610};
    int exp_chit[3] = '{0, 0, 1};

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_cx_def", cx_o[0], 320);
        chk("rst_cy_def", cy_o[0], 240);
        chk("rst_cx_clamp", cx_o[1], 608);
        chk("rst_cx_wrap", cx_o[2], 610);
        chk("rst_speed", spd_o[0], 1);
        chk("rst_moving", mov_o[0], 0);
        chk("rst_hit", hit_o[0], 0);
        rst_n = 1'b1;

        // Hold right for nine frames: ramp profile, clamp and wrap at the edge.
        set_btn(0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            do_tick();
            chk($sformatf("ramp_cx_%0d", k), cx_o[0], exp_cx[k]);
            chk($sformatf("ramp_speed_%0d", k), spd_o[0], exp_spd[k]);
            chk($sformatf("ramp_moving_%0d", k), mov_o[0], 1);
            if (k < 3) begin
                chk($sformatf("clamp_cx_%0d", k), cx_o[1], exp_ccx[k]);
                chk($sformatf("clamp_hit_%0d", k), hit_o[1], exp_chit[k]);
            end
            if (k == 0) begin
                chk("wrap_cx", cx_o[2], 30);
                chk("wrap_hit", hit_o[2], 1);
            end
        end

        // Release: position holds, speed falls back.
        set_btn(0, 0, 0, 0);
        do_tick();
        chk("release_cx", cx_o[0], 335);
        chk("release_speed", spd_o[0], 1);
        chk("release_moving", mov_o[0], 0);

        // Re-press restarts at the minimum step.
        set_btn(0, 0, 0, 1);
        do_tick();
        chk("repress_cx", cx_o[0], 336);
        chk("repress_speed", spd_o[0], 1);

        // Freeze with right held: no motion.
        freeze = 1'b1;
        do_tick();
        chk("freeze_cx", cx_o[0], 336);
        chk("freeze_speed", spd_o[0], 1);
        chk("freeze_moving", mov_o[0], 0);
        @(posedge pixel_clk);
        #1 freeze = 1'b0;

        // Ramp back up to speed 3, then reset between clock edges.
        for (int k = 0; k < 8; k++) do_tick();
        chk("preset_speed", spd_o[0], 3);
        chk("preset_cx", cx_o[0], 348);
        @(posedge pixel_clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_cx", cx_o[0], 320);
        chk("midrst_cy", cy_o[0], 240);
        chk("midrst_speed", spd_o[0], 1);
        chk("midrst_moving", mov_o[0], 0);
        #2 rst_n = 1'b1;

        // Left+right cancel, up still moves.
        set_btn(1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            chk($sformatf("cancel_cx_%0d", k), cx_o[0], 320);
            chk($sformatf("cancel_cy_%0d", k), cy_o[0], 239 - k);
        end

        // vs held high for 1000 cycles gives exactly one step.
        set_btn(0, 0, 0, 1);
        @(posedge pixel_clk);
        #1 vs = 1'b1;
        repeat (1000) @(posedge pixel_clk);
        #1 vs = 1'b0;
        chk("vs_high_cx", cx_o[0], 321);
        chk("vs_high_cy", cy_o[0], 237);

        // Long diagonal run: cruise, clamp at low X / high Y, wrap both axes.
        set_btn(0, 1, 1, 0);
        for (int k = 0; k < 60; k++) do_tick();
        chk("long_speed", spd_o[0], 8);
        chk("long_cx", cx_o[0], 30);
        chk("long_cy", cy_o[0], 450);

        repeat (3) @(posedge pixel_clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
